count_controller: RTL and testbench

Parametrised command controller for the photon-counter FPGA. It decodes opcode/argument words from the SPI receiver and sequences the counter bank through a counter clear, a programmable counting gate, end-of-count and per-channel readout. It sits between the SPI slave and the N-channel photon counters. It adds gate timing, abort/stop, channel-addressed read with handshake, and error flagging.

---
 rtl/count_ctrl_pkg.sv | 23 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/count_controller.sv | 187 ++++++++++++++++++
 tb/tb_count_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared opcodes, state encoding and command-word field layout for the photon-counter controller.
package count_ctrl_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ABORT    = 4'd0;
  localparam logic [OP_W-1:0] OP_START    = 4'd1;
  localparam logic [OP_W-1:0] OP_SET_GATE = 4'd2;
  localparam logic [OP_W-1:0] OP_READ     = 4'd3;
  localparam logic [OP_W-1:0] OP_STOP     = 4'd4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_COUNT = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

  // Opcode occupies the top OP_W bits of the command word.
  function automatic int unsigned op_lsb(input int unsigned cmd_w);
    return cmd_w - OP_W;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV enabled cycles, restartable via clr_i.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_controller.sv
// Command decoder and gate sequencer for the N-channel photon counter bank.
module count_controller
  import count_ctrl_pkg::*;
#(
  parameter int unsigned CMD_W    = 16,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned TICK_DIV = 1000,
  localparam int unsigned RCH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CMD_W-1:0] RX_DATA,
  input  logic             RX_VALID,
  input  logic             TX_ACK,
  output logic             COUNT_CLR,
  output logic             COUNT_EN,
  output logic             END_COUNT,
  output logic             READ_DATA,
  output logic [RCH_W-1:0] READ_CH,
  output logic             CMD_ERR,
  output logic [2:0]       STATE
);

  localparam int unsigned ARG_W  = CMD_W - OP_W;
  localparam int unsigned TCNT_W = ARG_W + $clog2(TICK_DIV);
  localparam int unsigned OP_LSB = op_lsb(CMD_W);
  localparam logic [ARG_W:0] NCH_LIM = (ARG_W + 1)'(N_CH);

  logic [OP_W-1:0]   rx_op;
  logic [ARG_W-1:0]  rx_arg;
  logic              cmd_abort, cmd_start, cmd_set_gate, cmd_read, cmd_stop;
  logic              tick, expire, presc_clr, presc_en;

  logic [2:0]        state_d, state_q;
  logic [ARG_W-1:0]  gate_d, gate_q;
  logic [TCNT_W-1:0] tick_cnt_d, tick_cnt_q;
  logic [RCH_W-1:0]  read_ch_d, read_ch_q;
  logic              count_clr_d, count_clr_q;
  logic              count_en_d, count_en_q;
  logic              end_count_d, end_count_q;
  logic              read_data_d, read_data_q;
  logic              cmd_err_d, cmd_err_q;

  assign rx_op  = RX_DATA[OP_LSB +: OP_W];
  assign rx_arg = RX_DATA[ARG_W-1:0];

  assign cmd_abort    = RX_VALID && (rx_op == OP_ABORT);
  assign cmd_start    = RX_VALID && (rx_op == OP_START);
  assign cmd_set_gate = RX_VALID && (rx_op == OP_SET_GATE);
  assign cmd_read     = RX_VALID && (rx_op == OP_READ);
  assign cmd_stop     = RX_VALID && (rx_op == OP_STOP);

  assign presc_clr = (state_q == ST_CLEAR);
  assign presc_en  = (state_q == ST_COUNT);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (presc_clr),
    .en_i  (presc_en),
    .tick_o(tick)
  );

  assign expire = tick && (tick_cnt_q == TCNT_W'(1));

  always_comb begin
    state_d     = state_q;
    gate_d      = gate_q;
    tick_cnt_d  = tick_cnt_q;
    read_ch_d   = read_ch_q;
    count_clr_d = 1'b0;
    count_en_d  = 1'b0;
    end_count_d = 1'b0;
    read_data_d = 1'b0;
    cmd_err_d   = 1'b0;

    if (cmd_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_start) begin
            state_d     = ST_CLEAR;
            count_clr_d = 1'b1;
          end else if (cmd_set_gate) begin
            gate_d = rx_arg;
          end else if (RX_VALID) begin
            cmd_err_d = 1'b1;
          end
        end
        ST_CLEAR: begin
          cmd_err_d = RX_VALID;
          if (gate_q != '0) begin
            state_d    = ST_COUNT;
            count_en_d = 1'b1;
            tick_cnt_d = TCNT_W'(gate_q);
          end else begin
            state_d     = ST_DONE;
            end_count_d = 1'b1;
          end
        end
        ST_COUNT: begin
          // Expiry wins; a coincident STOP merges into the same END_COUNT.
          if (expire) begin
            state_d     = ST_DONE;
            end_count_d = 1'b1;
            tick_cnt_d  = '0;
            cmd_err_d   = RX_VALID && !cmd_stop;
          end else if (cmd_stop) begin
            state_d     = ST_DONE;
            end_count_d = 1'b1;
          end else begin
            count_en_d = 1'b1;
            cmd_err_d  = RX_VALID;
            if (tick) begin
              tick_cnt_d = tick_cnt_q - 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (cmd_read) begin
            if ({1'b0, rx_arg} < NCH_LIM) begin
              state_d     = ST_READ;
              read_ch_d   = rx_arg[RCH_W-1:0];
              read_data_d = 1'b1;
            end else begin
              cmd_err_d = 1'b1;
            end
          end else if (cmd_start) begin
            state_d     = ST_CLEAR;
            count_clr_d = 1'b1;
          end else if (cmd_set_gate) begin
            gate_d = rx_arg;
          end else if (RX_VALID) begin
            cmd_err_d = 1'b1;
          end
        end
        ST_READ: begin
          cmd_err_d = RX_VALID;
          if (TX_ACK) begin
            state_d = ST_DONE;
          end else begin
            read_data_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      gate_q      <= '0;
      tick_cnt_q  <= '0;
      read_ch_q   <= '0;
      count_clr_q <= 1'b0;
      count_en_q  <= 1'b0;
      end_count_q <= 1'b0;
      read_data_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_q      <= gate_d;
      tick_cnt_q  <= tick_cnt_d;
      read_ch_q   <= read_ch_d;
      count_clr_q <= count_clr_d;
      count_en_q  <= count_en_d;
      end_count_q <= end_count_d;
      read_data_q <= read_data_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign STATE     = state_q;
  assign READ_CH   = read_ch_q;
  assign COUNT_CLR = count_clr_q;
  assign COUNT_EN  = count_en_q;
  assign END_COUNT = end_count_q;
  assign READ_DATA = read_data_q;
  assign CMD_ERR   = cmd_err_q;

endmodule

// File: tb/tb_count_controller.sv
// Scenario bench for count_controller: pulse counts and timing derived from gate arithmetic.
module tb_count_controller;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        tx_ack;
  logic        count_clr, count_en, end_count, read_data, cmd_err;
  logic [1:0]  read_ch;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_clr, n_en, n_end, n_err, end_cyc;

  always #5 clk = ~clk;

  count_controller #(
    .CMD_W   (16),
    .N_CH    (4),
    .TICK_DIV(D)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .TX_ACK   (tx_ack),
    .COUNT_CLR(count_clr),
    .COUNT_EN (count_en),
    .END_COUNT(end_count),
    .READ_DATA(read_data),
    .READ_CH  (read_ch),
    .CMD_ERR  (cmd_err),
    .STATE    (state)
  );

  task automatic mon_clear();
    n_clr = 0; n_en = 0; n_end = 0; n_err = 0; end_cyc = -1;
  endtask

  // Advance one cycle and tally the outputs seen mid-cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (count_clr) n_clr++;
    if (count_en) n_en++;
    if (end_count) begin
      n_end++;
      end_cyc = cyc;
    end
    if (cmd_err) n_err++;
  endtask

  task automatic send(input logic [3:0] op, input logic [11:0] arg);
    rx_data  = {op, arg};
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_checks++;
    if ({count_clr, count_en, end_count, read_data, cmd_err} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000",
               {count_clr, count_en, end_count, read_data, cmd_err});
    else n_pass++;
    n_checks++;
    if (read_ch !== 2'd0) $display("FAIL reset_read_ch: got %0d want 0", read_ch); else n_pass++;
  endtask

  task automatic test_gate(input int g);
    int c1;
    mon_clear();
    send(4'd2, 12'(g));
    send(4'd1, 12'd0);
    c1 = cyc;
    n_checks++;
    if (count_clr !== 1'b1) $display("FAIL gate%0d_clr_pulse: got %b want 1", g, count_clr);
    else n_pass++;
    repeat (g * D + 6) step();
    n_checks++;
    if (n_clr !== 1) $display("FAIL gate%0d_clr_count: got %0d want 1", g, n_clr); else n_pass++;
    n_checks++;
    if (n_en !== g * D) $display("FAIL gate%0d_en_len: got %0d want %0d", g, n_en, g * D);
    else n_pass++;
    n_checks++;
    if (n_end !== 1 || end_cyc !== c1 + 1 + g * D)
      $display("FAIL gate%0d_end: got n=%0d at %0d want 1 at %0d", g, n_end, end_cyc - c1,
               1 + g * D);
    else n_pass++;
    n_checks++;
    if (state !== 3'd3 || n_err !== 0)
      $display("FAIL gate%0d_done: got state=%0d err=%0d want 3/0", g, state, n_err);
    else n_pass++;
  endtask

  task automatic test_stop();
    mon_clear();
    send(4'd2, 12'd100);
    send(4'd1, 12'd0);
    for (int i = 0; i < 60 && n_en < 7; i++) step();
    send(4'd4, 12'd0);
    n_checks++;
    if (count_en !== 1'b0 || end_count !== 1'b1)
      $display("FAIL stop_edge: got en=%b end=%b want 0/1", count_en, end_count);
    else n_pass++;
    repeat (5) step();
    n_checks++;
    if (n_en !== 7 || n_end !== 1 || state !== 3'd3)
      $display("FAIL stop_totals: got en=%0d end=%0d st=%0d want 7/1/3", n_en, n_end, state);
    else n_pass++;
  endtask

  task automatic test_read();
    int ch;
    int wait_n;
    ch = int'($urandom_range(0, 3));
    wait_n = int'($urandom_range(1, 6));
    mon_clear();
    send(4'd3, 12'(ch));
    n_checks++;
    if (read_data !== 1'b1 || read_ch !== 2'(ch))
      $display("FAIL read_start: got rd=%b ch=%0d want 1/%0d", read_data, read_ch, ch);
    else n_pass++;
    repeat (wait_n) step();
    n_checks++;
    if (read_data !== 1'b1 || read_ch !== 2'(ch) || state !== 3'd4)
      $display("FAIL read_hold: got rd=%b ch=%0d st=%0d want 1/%0d/4", read_data, read_ch, state,
               ch);
    else n_pass++;
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    n_checks++;
    if (read_data !== 1'b0 || state !== 3'd3)
      $display("FAIL read_ack: got rd=%b st=%0d want 0/3", read_data, state);
    else n_pass++;
    send(4'd3, 12'($urandom_range(4, 4095)));
    n_checks++;
    if (cmd_err !== 1'b1 || read_data !== 1'b0 || state !== 3'd3)
      $display("FAIL read_range: got err=%b rd=%b st=%0d want 1/0/3", cmd_err, read_data, state);
    else n_pass++;
  endtask

  task automatic test_errors();
    send(4'd0, 12'd0);
    mon_clear();
    send(4'd3, 12'd1);
    n_checks++;
    if (cmd_err !== 1'b1 || state !== 3'd0)
      $display("FAIL err_read_idle: got err=%b st=%0d want 1/0", cmd_err, state);
    else n_pass++;
    send(4'd9, 12'd0);
    n_checks++;
    if (cmd_err !== 1'b1 || state !== 3'd0)
      $display("FAIL err_illegal: got err=%b st=%0d want 1/0", cmd_err, state);
    else n_pass++;
    mon_clear();
    send(4'd2, 12'd2);
    send(4'd1, 12'd0);
    step(); step();
    send(4'd1, 12'd0);
    send(4'd2, 12'd5);
    send(4'(int'($urandom_range(5, 15))), 12'd0);
    repeat (15) step();
    n_checks++;
    if (n_err !== 3 || n_en !== 2 * D || n_end !== 1)
      $display("FAIL err_in_count: got err=%0d en=%0d end=%0d want 3/%0d/1", n_err, n_en, n_end,
               2 * D);
    else n_pass++;
  endtask

  task automatic test_expiry_cmd();
    mon_clear();
    send(4'd2, 12'd1);
    send(4'd1, 12'd0);
    for (int i = 0; i < 20 && n_en < D; i++) step();
    send(4'd4, 12'd0);
    repeat (3) step();
    n_checks++;
    if (n_end !== 1 || n_err !== 0 || state !== 3'd3 || n_en !== D)
      $display("FAIL expiry_stop: got end=%0d err=%0d st=%0d en=%0d want 1/0/3/%0d", n_end,
               n_err, state, n_en, D);
    else n_pass++;
    mon_clear();
    send(4'd1, 12'd0);
    for (int i = 0; i < 20 && n_en < D; i++) step();
    send(4'd1, 12'd0);
    n_checks++;
    if (cmd_err !== 1'b1 || end_count !== 1'b1 || state !== 3'd3)
      $display("FAIL expiry_start: got err=%b end=%b st=%0d want 1/1/3", cmd_err, end_count,
               state);
    else n_pass++;
  endtask

  task automatic test_abort_rst();
    int c1;
    mon_clear();
    send(4'd2, 12'd3);
    send(4'd1, 12'd0);
    for (int i = 0; i < 20 && n_en < 5; i++) step();
    send(4'd0, 12'd0);
    repeat (3) step();
    n_checks++;
    if (state !== 3'd0 || n_end !== 0 || count_en !== 1'b0)
      $display("FAIL abort_mid: got st=%0d end=%0d en=%b want 0/0/0", state, n_end, count_en);
    else n_pass++;
    mon_clear();
    send(4'd1, 12'd0);
    repeat (3 * D + 4) step();
    n_checks++;
    if (n_en !== 3 * D || n_end !== 1)
      $display("FAIL abort_keeps_gate: got en=%0d end=%0d want %0d/1", n_en, n_end, 3 * D);
    else n_pass++;
    mon_clear();
    send(4'd1, 12'd0);
    for (int i = 0; i < 20 && n_en < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (state !== 3'd0 || n_end !== 0 || count_en !== 1'b0)
      $display("FAIL rst_mid: got st=%0d end=%0d en=%b want 0/0/0", state, n_end, count_en);
    else n_pass++;
    mon_clear();
    send(4'd1, 12'd0);
    c1 = cyc;
    repeat (4) step();
    n_checks++;
    if (n_en !== 0 || n_end !== 1 || end_cyc !== c1 + 1)
      $display("FAIL rst_clears_gate: got en=%0d end=%0d at %0d want 0/1 at 1", n_en, n_end,
               end_cyc - c1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_gate(3);
    test_gate(int'($urandom_range(1, 6)));
    test_gate(0);
    test_gate(int'($urandom_range(1, 9)));
    test_stop();
    test_read();
    test_read();
    test_errors();
    test_expiry_cmd();
    test_abort_rst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
